// File: rtl/banco_registradores.sv
// Ten-entry register bank for the calculator: load/add/sub on one register,
// or a sequential clear of the whole bank, one command at a time.
module banco_registradores #(
    parameter int LARGURA  = 8,
    parameter int NUM_REGS = 10
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               Escreve,
    input  logic [1:0]         Operacao,
    input  logic [3:0]         Endereco,
    input  logic [LARGURA-1:0] DadoEntrada,
    output logic               Ocupado,
    output logic               Pronto,
    output logic               Erro,
    output logic [LARGURA-1:0] Dado0,
    output logic [LARGURA-1:0] Dado1,
    output logic [LARGURA-1:0] Dado2,
    output logic [LARGURA-1:0] Dado3,
    output logic [LARGURA-1:0] Dado4,
    output logic [LARGURA-1:0] Dado5,
    output logic [LARGURA-1:0] Dado6,
    output logic [LARGURA-1:0] Dado7,
    output logic [LARGURA-1:0] Dado8,
    output logic [LARGURA-1:0] Dado9
);

    typedef enum logic [1:0] {
        OCIOSO,
        EXECUTA,
        LIMPA
    } estado_t;

    localparam logic [1:0] OP_CARREGA = 2'b00;
    localparam logic [1:0] OP_SOMA    = 2'b01;
    localparam logic [1:0] OP_SUBTRAI = 2'b10;
    localparam logic [1:0] OP_LIMPA   = 2'b11;
    localparam logic [3:0] ULTIMO_IDX = 4'(NUM_REGS - 1);

    estado_t            r_estado;
    logic [LARGURA-1:0] r_regs [NUM_REGS];
    logic [1:0]         r_op;
    logic [3:0]         r_end;
    logic [LARGURA-1:0] r_dado;
    logic [3:0]         r_idx;
    logic               r_ocupado;
    logic               r_pronto;
    logic               r_erro;

    logic [LARGURA-1:0] w_atual;
    logic [LARGURA:0]   w_soma;
    logic [LARGURA:0]   w_dif;
    logic               w_end_ok;

    // Current value of the addressed register; zero for out-of-range addresses.
    always_comb begin
        w_atual = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_end == 4'(i)) begin
                w_atual = r_regs[i];
            end
        end
    end

    assign w_soma   = {1'b0, w_atual} + {1'b0, r_dado};
    assign w_dif    = {1'b0, w_atual} - {1'b0, r_dado};
    assign w_end_ok = (r_end <= ULTIMO_IDX);

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_estado  <= OCIOSO;
            r_op      <= OP_CARREGA;
            r_end     <= '0;
            r_dado    <= '0;
            r_idx     <= '0;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
            r_erro    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (Escreve) begin
                        r_op      <= Operacao;
                        r_end     <= Endereco;
                        r_dado    <= DadoEntrada;
                        r_idx     <= '0;
                        r_erro    <= 1'b0;
                        r_ocupado <= 1'b1;
                        r_estado  <= (Operacao == OP_LIMPA) ? LIMPA : EXECUTA;
                    end
                end
                EXECUTA: begin
                    if (!w_end_ok) begin
                        r_erro <= 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (r_end == 4'(i)) begin
                                case (r_op)
                                    OP_CARREGA: r_regs[i] <= r_dado;
                                    OP_SOMA:    r_regs[i] <= w_soma[LARGURA-1:0];
                                    OP_SUBTRAI: r_regs[i] <= w_dif[LARGURA-1:0];
                                    default:    r_regs[i] <= r_regs[i];
                                endcase
                            end
                        end
                        if (r_op == OP_SOMA) begin
                            r_erro <= w_soma[LARGURA];
                        end else if (r_op == OP_SUBTRAI) begin
                            r_erro <= (w_atual < r_dado);
                        end
                    end
                    r_pronto  <= 1'b1;
                    r_ocupado <= 1'b0;
                    r_estado  <= OCIOSO;
                end
                LIMPA: begin
                    // One register per cycle; untouched ones stay visible until their turn.
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (r_idx == 4'(i)) begin
                            r_regs[i] <= '0;
                        end
                    end
                    if (r_idx == ULTIMO_IDX) begin
                        r_pronto  <= 1'b1;
                        r_ocupado <= 1'b0;
                        r_estado  <= OCIOSO;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                default: begin
                    r_ocupado <= 1'b0;
                    r_estado  <= OCIOSO;
                end
            endcase
        end
    end

    assign Ocupado = r_ocupado;
    assign Pronto  = r_pronto;
    assign Erro    = r_erro;
    assign Dado0   = r_regs[0];
    assign Dado1   = r_regs[1];
    assign Dado2   = r_regs[2];
    assign Dado3   = r_regs[3];
    assign Dado4   = r_regs[4];
    assign Dado5   = r_regs[5];
    assign Dado6   = r_regs[6];
    assign Dado7   = r_regs[7];
    assign Dado8   = r_regs[8];
    assign Dado9   = r_regs[9];

endmodule

// File: tb/tb_banco_registradores.sv
// Directed bench for banco_registradores: one task per scenario, each with
// its own inline checks against hand-computed values.
module tb_banco_registradores;

    logic       Clock;
    logic       Reset_n;
    logic       Escreve;
    logic [1:0] Operacao;
    logic [3:0] Endereco;
    logic [7:0] DadoEntrada;
    logic       Ocupado;
    logic       Pronto;
    logic       Erro;
    logic [7:0] Dado0, Dado1, Dado2, Dado3, Dado4, Dado5, Dado6, Dado7, Dado8, Dado9;
    logic [7:0] w_dado [10];

    int checks = 0;
    int errors = 0;
    logic [7:0] mdl [10];

    banco_registradores #(.LARGURA(8), .NUM_REGS(10)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Escreve(Escreve), .Operacao(Operacao),
        .Endereco(Endereco), .DadoEntrada(DadoEntrada), .Ocupado(Ocupado),
        .Pronto(Pronto), .Erro(Erro),
        .Dado0(Dado0), .Dado1(Dado1), .Dado2(Dado2), .Dado3(Dado3), .Dado4(Dado4),
        .Dado5(Dado5), .Dado6(Dado6), .Dado7(Dado7), .Dado8(Dado8), .Dado9(Dado9)
    );

    assign w_dado[0] = Dado0;
    assign w_dado[1] = Dado1;
    assign w_dado[2] = Dado2;
    assign w_dado[3] = Dado3;
    assign w_dado[4] = Dado4;
    assign w_dado[5] = Dado5;
    assign w_dado[6] = Dado6;
    assign w_dado[7] = Dado7;
    assign w_dado[8] = Dado8;
    assign w_dado[9] = Dado9;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Presents a command for exactly the accept edge; returns just after it.
    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
        Escreve = 1'b1; Operacao = op; Endereco = a; DadoEntrada = d;
        tick();
        Escreve = 1'b0;
    endtask

    task automatic test_reset();
        issue(2'b00, 4'd0, 8'hAB); tick();
        issue(2'b00, 4'd9, 8'h11); tick();
        checks++;
        if (Dado0 !== 8'hAB || Dado9 !== 8'h11) begin
            errors++;
            $display("[TB] FAIL reset_preload: Dado0=%h Dado9=%h expected AB 11", Dado0, Dado9);
        end
        Reset_n = 1'b0;
        tick(); tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mdl[i] = 8'h00;
            checks++;
            if (w_dado[i] !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_dado%0d: got %h expected 00", i, w_dado[i]);
            end
        end
        checks++;
        if ({Ocupado, Pronto, Erro} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {Ocupado, Pronto, Erro});
        end
    endtask

    task automatic test_load_add();
        issue(2'b00, 4'd3, 8'h7F);
        checks++;
        if ({Ocupado, Pronto} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL load_accept: Ocupado,Pronto=%b expected 10", {Ocupado, Pronto});
        end
        tick();
        checks++;
        if (Pronto !== 1'b1 || Ocupado !== 1'b0 || Erro !== 1'b0 || Dado3 !== 8'h7F) begin
            errors++;
            $display("[TB] FAIL load_done: P=%b O=%b E=%b Dado3=%h expected 1 0 0 7F",
                     Pronto, Ocupado, Erro, Dado3);
        end
        issue(2'b01, 4'd3, 8'h01);
        checks++;
        if (Pronto !== 1'b0 || Ocupado !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pronto_pulse: P=%b O=%b expected 0 1", Pronto, Ocupado);
        end
        tick();
        checks++;
        if (Pronto !== 1'b1 || Erro !== 1'b0 || Dado3 !== 8'h80) begin
            errors++;
            $display("[TB] FAIL add_done: P=%b E=%b Dado3=%h expected 1 0 80", Pronto, Erro, Dado3);
        end
        mdl[3] = 8'h80;
    endtask

    task automatic test_carry_borrow();
        issue(2'b00, 4'd5, 8'hF0); tick();
        issue(2'b01, 4'd5, 8'h20); tick();
        checks++;
        if (Dado5 !== 8'h10 || Erro !== 1'b1 || Pronto !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_carry: Dado5=%h E=%b P=%b expected 10 1 1", Dado5, Erro, Pronto);
        end
        tick();
        checks++;
        if (Erro !== 1'b1 || Pronto !== 1'b0) begin
            errors++;
            $display("[TB] FAIL erro_hold: E=%b P=%b expected 1 0", Erro, Pronto);
        end
        issue(2'b10, 4'd5, 8'h11);
        checks++;
        if (Erro !== 1'b0) begin
            errors++;
            $display("[TB] FAIL erro_clear_sub: got %b expected 0", Erro);
        end
        tick();
        checks++;
        if (Dado5 !== 8'hFF || Erro !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sub_borrow: Dado5=%h E=%b expected FF 1", Dado5, Erro);
        end
        issue(2'b00, 4'd5, 8'h00);
        checks++;
        if (Erro !== 1'b0) begin
            errors++;
            $display("[TB] FAIL erro_clear_load: got %b expected 0", Erro);
        end
        tick();
        checks++;
        if (Dado5 !== 8'h00 || Erro !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_zero: Dado5=%h E=%b expected 00 0", Dado5, Erro);
        end
        issue(2'b10, 4'd5, 8'h00); tick();
        checks++;
        if (Dado5 !== 8'h00 || Erro !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sub_equal: Dado5=%h E=%b expected 00 0", Dado5, Erro);
        end
        mdl[5] = 8'h00;
    endtask

    task automatic test_bad_addr_busy();
        Escreve = 1'b1; Operacao = 2'b00; Endereco = 4'd12; DadoEntrada = 8'hAA;
        tick();
        Endereco = 4'd0; DadoEntrada = 8'hEE;
        tick();
        Escreve = 1'b0;
        checks++;
        if (Pronto !== 1'b1 || Erro !== 1'b1 || Ocupado !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_addr: P=%b E=%b O=%b expected 1 1 0", Pronto, Erro, Ocupado);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (w_dado[i] !== mdl[i]) begin
                errors++;
                $display("[TB] FAIL bad_addr_dado%0d: got %h expected %h", i, w_dado[i], mdl[i]);
            end
        end
        tick();
        checks++;
        if (Ocupado !== 1'b0 || Pronto !== 1'b0 || Dado0 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL busy_ignored: O=%b P=%b Dado0=%h expected 0 0 00", Ocupado, Pronto, Dado0);
        end
    endtask

    task automatic test_clear_all();
        for (int i = 0; i < 10; i++) begin
            issue(2'b00, 4'(i), 8'h55); tick();
        end
        issue(2'b11, 4'd7, 8'h00);
        checks++;
        if (Ocupado !== 1'b1 || Dado0 !== 8'h55 || Dado9 !== 8'h55) begin
            errors++;
            $display("[TB] FAIL clear_accept: O=%b Dado0=%h Dado9=%h expected 1 55 55", Ocupado, Dado0, Dado9);
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            for (int j = 0; j < 10; j++) begin
                checks++;
                if (w_dado[j] !== ((j < k) ? 8'h00 : 8'h55)) begin
                    errors++;
                    $display("[TB] FAIL clear_step%0d_dado%0d: got %h expected %h",
                             k, j, w_dado[j], (j < k) ? 8'h00 : 8'h55);
                end
            end
            checks++;
            if (Ocupado !== (k < 10) || Pronto !== (k == 10)) begin
                errors++;
                $display("[TB] FAIL clear_step%0d_flags: O=%b P=%b expected %b %b",
                         k, Ocupado, Pronto, k < 10, k == 10);
            end
        end
        tick();
        checks++;
        if (Pronto !== 1'b0 || Erro !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_end: P=%b E=%b expected 0 0", Pronto, Erro);
        end
    endtask

    task automatic test_reset_during_clear();
        for (int i = 0; i < 10; i++) begin
            issue(2'b00, 4'(i), 8'h55); tick();
        end
        issue(2'b11, 4'd0, 8'h00);
        tick(); tick(); tick(); tick();
        checks++;
        if (Dado3 !== 8'h00 || Dado4 !== 8'h55 || Ocupado !== 1'b1) begin
            errors++;
            $display("[TB] FAIL partial_clear: Dado3=%h Dado4=%h O=%b expected 00 55 1", Dado3, Dado4, Ocupado);
        end
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (w_dado[i] !== 8'h00) begin
                errors++;
                $display("[TB] FAIL rst_clear_dado%0d: got %h expected 00", i, w_dado[i]);
            end
        end
        checks++;
        if ({Ocupado, Pronto, Erro} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL rst_clear_flags: got %b expected 000", {Ocupado, Pronto, Erro});
        end
        issue(2'b00, 4'd9, 8'h33);
        checks++;
        if (Ocupado !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_rst_accept: O=%b expected 1", Ocupado);
        end
        tick();
        checks++;
        if (Pronto !== 1'b1 || Dado9 !== 8'h33 || Dado8 !== 8'h00 || Erro !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_rst_load: P=%b Dado9=%h Dado8=%h E=%b expected 1 33 00 0",
                     Pronto, Dado9, Dado8, Erro);
        end
    endtask

    initial begin
        Reset_n = 1'b0; Escreve = 1'b0; Operacao = 2'b00; Endereco = 4'd0; DadoEntrada = 8'h00;
        tick(); tick();
        Reset_n = 1'b1;
        test_reset();
        test_load_add();
        test_carry_borrow();
        test_bad_addr_busy();
        test_clear_all();
        test_reset_during_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
